// File: rtl/decode_stage.sv
// Handshaked instruction-decode stage: classifies words into next-state codes,
// buffers results in an output register plus skid, and latches HALT until resumed.
module decode_stage #(
  parameter int                 INSN_W        = 32,
  parameter int                 PC_W          = 32,
  parameter int                 STATE_W       = 4,
  parameter logic [STATE_W-1:0] STATE_EXECUTE = 4'd1,
  parameter logic [STATE_W-1:0] STATE_HALT    = 4'd2,
  parameter logic [STATE_W-1:0] STATE_TRAP    = 4'd3,
  parameter logic [3:0]         KIND_LEGAL    = 4'b0000,
  parameter logic [15:0]        K0_LEGAL      = 16'h0000,
  parameter int                 CNT_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [INSN_W-1:0]  i_insn,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSN_W-1:0]  o_insn,
  output logic [STATE_W-1:0] o_to_state,
  output logic               o_illegal,
  output logic               o_halted,
  input  logic               i_flush,
  input  logic               i_resume,
  output logic [CNT_W-1:0]   o_illegal_cnt
);

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} fsm_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {state, illegal}; only the low 31 bits carry fields.
  function automatic logic [STATE_W:0] decode_f(input logic [30:0] insn);
    logic [1:0] k;
    logic [3:0] k0;
    logic       legal;
    logic [STATE_W-1:0] st;
    k     = insn[30:29];
    k0    = insn[28:25];
    st    = STATE_EXECUTE;
    legal = 1'b0;
    if (k != 2'd0) begin
      legal = KIND_LEGAL[k];
    end else if (k0 != 4'd0) begin
      legal = K0_LEGAL[k0];
    end else if (insn[24:0] == 25'd0) begin
      legal = 1'b1;
      st    = STATE_HALT;
    end else begin
      legal = 1'b0;
    end
    return {(legal ? st : STATE_TRAP), ~legal};
  endfunction

  logic               out_valid_q, out_valid_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic [INSN_W-1:0]  out_insn_q, out_insn_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  logic               out_ill_q, out_ill_d;
  logic               skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSN_W-1:0]  skid_insn_q, skid_insn_d;
  logic [STATE_W-1:0] skid_state_q, skid_state_d;
  logic               skid_ill_q, skid_ill_d;
  logic               ready_q, ready_d;
  logic               halted_q, halted_d;
  fsm_e               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept_s, xfer_s, take_s;
  logic [STATE_W:0]   dec_s;
  logic [STATE_W-1:0] new_state_s;
  logic               new_ill_s;

  assign accept_s    = i_valid & ready_q;
  assign xfer_s      = out_valid_q & i_ready;
  assign take_s      = accept_s & ~i_flush;
  assign dec_s       = decode_f(i_insn[30:0]);
  assign new_state_s = dec_s[STATE_W:1];
  assign new_ill_s   = dec_s[0];

  // Next-state for buffers, halt FSM, handshake and illegal counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_insn_d   = out_insn_q;
    out_state_d  = out_state_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_insn_d  = skid_insn_q;
    skid_state_d = skid_state_q;
    skid_ill_d   = skid_ill_q;
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer_s) begin
      if (skid_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = skid_pc_q;
        out_insn_d  = skid_insn_q;
        out_state_d = skid_state_q;
        out_ill_d   = skid_ill_q;
        if (accept_s) begin
          skid_pc_d    = i_pc;
          skid_insn_d  = i_insn;
          skid_state_d = new_state_s;
          skid_ill_d   = new_ill_s;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept_s) begin
        out_valid_d = 1'b1;
        out_pc_d    = i_pc;
        out_insn_d  = i_insn;
        out_state_d = new_state_s;
        out_ill_d   = new_ill_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      // Output is stalled: the new word parks in the skid.
      skid_valid_d = 1'b1;
      skid_pc_d    = i_pc;
      skid_insn_d  = i_insn;
      skid_state_d = new_state_s;
      skid_ill_d   = new_ill_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end

    case (fsm_q)
      RUN: begin
        if (take_s && !new_ill_s && (new_state_s == STATE_HALT)) fsm_d = HALTED;
        else fsm_d = RUN;
      end
      HALTED: begin
        if (i_resume) fsm_d = RUN;
        else fsm_d = HALTED;
      end
      default: fsm_d = RUN;
    endcase

    if (take_s && new_ill_s && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
    else cnt_d = cnt_q;

    ready_d  = ~skid_valid_d & (fsm_d == RUN);
    halted_d = (fsm_d == HALTED);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= {PC_W{1'b0}};
      out_insn_q   <= {INSN_W{1'b0}};
      out_state_q  <= {STATE_W{1'b0}};
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= {PC_W{1'b0}};
      skid_insn_q  <= {INSN_W{1'b0}};
      skid_state_q <= {STATE_W{1'b0}};
      skid_ill_q   <= 1'b0;
      ready_q      <= 1'b1;
      halted_q     <= 1'b0;
      fsm_q        <= RUN;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_insn_q   <= out_insn_d;
      out_state_q  <= out_state_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_insn_q  <= skid_insn_d;
      skid_state_q <= skid_state_d;
      skid_ill_q   <= skid_ill_d;
      ready_q      <= ready_d;
      halted_q     <= halted_d;
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = out_valid_q;
  assign o_pc          = out_pc_q;
  assign o_insn        = out_insn_q;
  assign o_to_state    = out_state_q;
  assign o_illegal     = out_ill_q;
  assign o_halted      = halted_q;
  assign o_illegal_cnt = cnt_q;

endmodule
